// File: rtl/gated_reg_bank_pkg.sv
// Shared defaults and helpers for the gated register bank.
package gated_reg_bank_pkg;
  localparam int CH_DEF    = 4;
  localparam int W_DEF     = 8;
  localparam int HOLD_DEF  = 2;
  localparam int CNT_W_DEF = 8;

  // Hold counter must represent 0..HOLD_CYCLES; keep at least one bit when HOLD_CYCLES=0.
  function automatic int hold_w(input int hold_cycles);
    return (hold_cycles < 1) ? 1 : $clog2(hold_cycles + 1);
  endfunction
endpackage

// File: rtl/gated_reg_bank_icg_cell.sv
// Latch-based integrated clock gate: enable captured while clk is low, gclk = clk & latched enable.
// Behavioural model interchangeable with a library ICG cell; this is the only latch in the design.
module icg_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic test_en,
  output logic gclk,
  output logic en_lat
);
  always_latch begin
    if (!rst_n)
      en_lat <= 1'b0;
    else if (!clk)
      en_lat <= en | test_en;
  end

  assign gclk = clk & en_lat;
endmodule

// File: rtl/gated_reg_bank.sv
// Bank of CH W-bit registers, each on its own gated clock with an enable hold-off window
// and a saturating count of suppressed edges.
module gated_reg_bank
  import gated_reg_bank_pkg::*;
#(
  parameter int CH          = CH_DEF,
  parameter int W           = W_DEF,
  parameter int HOLD_CYCLES = HOLD_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              test_en,
  input  logic [CH-1:0]     en,
  input  logic [CH*W-1:0]   d,
  input  logic              cnt_clr,
  output logic [CH*W-1:0]   q,
  output logic [CH-1:0]     clk_active,
  output logic [CH*CNT_W-1:0] gate_cnt
);
  localparam int HW = hold_w(HOLD_CYCLES);
  localparam logic [HW-1:0]    HOLD_LD = HW'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [HW-1:0]    r_hold;
    logic [W-1:0]     r_q;
    logic [CNT_W-1:0] r_cnt;
    logic             w_ce;
    logic             w_gclk;
    logic             w_lat;

    // test_en enters only at the gate, so it never extends the hold window.
    assign w_ce = en[i] | (r_hold != '0);

    icg_cell u_icg (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (w_ce),
      .test_en (test_en),
      .gclk    (w_gclk),
      .en_lat  (w_lat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        r_hold <= '0;
      else if (en[i])
        r_hold <= HOLD_LD;
      else if (r_hold != '0)
        r_hold <= r_hold - HW'(1);
    end

    always_ff @(posedge w_gclk or negedge rst_n) begin
      if (!rst_n)
        r_q <= '0;
      else
        r_q <= d[i*W +: W];
    end

    // w_lat is stable through the high phase, so it reflects whether this edge was passed.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        r_cnt <= '0;
      else if (cnt_clr)
        r_cnt <= '0;
      else if (!w_lat && (r_cnt != CNT_MAX))
        r_cnt <= r_cnt + CNT_W'(1);
    end

    assign q[i*W +: W]            = r_q;
    assign gate_cnt[i*CNT_W +: CNT_W] = r_cnt;
    assign clk_active[i]          = w_lat;
  end
endmodule

// File: doc/gated_reg_bank.md
# gated_reg_bank

Parametrised bank of CH independent W-bit registers, each clocked by its own latch-based integrated clock gate (ICG). Each channel has an enable with a programmable hold-off, so its clock keeps running for HOLD_CYCLES edges after the enable drops. A scan/test override forces all gates open. Each channel also has a saturating counter of gated cycles for power observability. The block is the multi-channel successor to the single-bit latch-gated D flip-flop and sits between datapath producers and low-activity state registers.

## Interface
- CH, 4, number of channels
- W, 8, data width per channel
- HOLD_CYCLES, 2, extra clock edges passed after en[i] falls (0 = pure enable gating)
- CNT_W, 8, width of each gated-cycle counter
- clk  in  1  free-running global clock
- rst_n  in  1  asynchronous active-low reset
- test_en  in  1  forces every channel clock enable high (scan/test)
- en  in  CH  per-channel clock enable
- d  in  CH*W  channel i data on bits [i*W +: W]
- cnt_clr  in  1  synchronous clear of all gated-cycle counters
- q  out  CH*W  channel i register on bits [i*W +: W]
- clk_active  out  CH  latched enable of channel i (1 = gated clock passes the current high phase)
- gate_cnt  out  CH*CNT_W  channel i gated-cycle count on bits [i*CNT_W +: CNT_W]

## Operation
- Per channel, the raw enable is ce[i] = en[i] | test_en | (hold[i] != 0).
- The ICG latch is transparent while clk is low and holds while clk is high. The gated clock is gclk[i] = clk & ce_lat[i], so it is glitch-free.
- hold[i] counter, width clog2(HOLD_CYCLES+1), clocked on clk:
  - en[i]=1 → load HOLD_CYCLES.
  - Otherwise, if hold[i] != 0 → decrement.
  - test_en does not load it.
- Data register: q[i] <= d[i] on posedge gclk[i]. The value holds when the channel is gated.
- gate_cnt[i], clocked on clk:
  - cnt_clr=1 → 0. Clear wins over increment.
  - Else, if ce_lat[i]=0 at the edge → increment, saturating at 2^CNT_W-1.
- clk_active[i] = ce_lat[i].
- Reset (rst_n=0) is asynchronous and independent of the gated clocks:
  - q=0, hold=0, gate_cnt=0.
  - The ICG latch is forced to 0, so clk_active=0.
- After reset release, a channel passes its first edge only once ce[i] is latched during a low phase.

## Timing
- Enable-to-edge: en[i] must be stable during the clk low phase before edge k. Edge k is then passed, and q updates from d at edge k (0 cycles of latency beyond the enabled edge).
- With en[i] high at edge k and low afterwards, edges k+1 … k+HOLD_CYCLES are also passed. The first suppressed edge is k+HOLD_CYCLES+1.
- Because hold[i] updates on the clk edge, the next low phase latches the post-edge value.
- en[i] toggling while clk is high has no effect until the following low phase; the latch blocks the glitch.
- Re-asserting en[i] during a hold window reloads hold[i] to HOLD_CYCLES, so the window restarts.
- test_en rising: every channel passes the next edge. test_en falling: channels whose hold[i]=0 and en[i]=0 gate on the next edge.
- gate_cnt[i] increments by exactly one per suppressed edge. Once it reaches 2^CNT_W-1 it stays there until cnt_clr.
- rst_n asserted mid-hold: the window is abandoned immediately. After release, the channel stays gated until en[i].

## Structure
- Package gated_reg_bank_pkg holds:
  - default parameter constants (CH_DEF, W_DEF, HOLD_DEF, CNT_W_DEF);
  - a clog2-based hold-counter width function.
- Sub-module icg_cell, instantiated CH times:
  - ports clk, rst_n, en, test_en, gclk, en_lat;
  - a latch transparent on clk low plus an AND gate.
  - It is the only place a latch is inferred, so it can be swapped for a library ICG cell.
- The top level generates per channel: the hold counter, the W-bit register on gclk[i], and the gate counter on clk.

## Test plan
All scenarios use CH=4, W=8, HOLD_CYCLES=2, CNT_W=8.
- Reset: drive d=0xFFFFFFFF with en=0xF and pulse rst_n low mid-cycle → q=0, gate_cnt=0, clk_active=0 asynchronously; after release, q=0xFFFFFFFF after the first enabled edge.
- Hold-off: en[0]=1 for one edge, d[0] changes every cycle (0x11, 0x22, 0x33, 0x44) → q[0] captures 0x11, 0x22 and 0x33 on edges k, k+1 and k+2, then holds 0x33; gate_cnt[0] increments from edge k+3.
- Glitch immunity: toggle en[1] only during the clk high phase → gclk[1] never pulses and q[1] is unchanged; gate_cnt[1] counts every edge.
- Test override: en=0 and test_en=1 for 5 edges → every channel captures d on each edge and gate_cnt is frozen; after test_en falls, channels gate on the next edge.
- Saturation and clear: en[2]=0 for 300 edges → gate_cnt[2]=255; cnt_clr pulsed on a gated edge → gate_cnt[2]=0 at that edge, then 1 at the next edge.
- Hold reload: en[3] pulses high at edges k and k+1 → edges k … k+3 pass and edge k+4 is gated.
